// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, commit queue entry type and write-enable decode for regfile_wb
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              vld;
    } wb_entry_t;

    // One-hot enable for the committing register; r0 never gets an enable.
    function automatic logic [NREGS-1:0] wen_decoder5_to_32(
        input logic [ADDR_W-1:0] addr,
        input logic              en
    );
        logic [NREGS-1:0] oh;
        oh           = '0;
        oh[addr]     = en;
        oh[ZERO_REG] = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - 2-entry ordered commit queue exposing head and tail for bypass compare
module wb_fifo2
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output wb_entry_t         head,
    output wb_entry_t         tail,
    output logic [1:0]        count
);

    wb_entry_t q0;
    wb_entry_t q1;
    wb_entry_t new_entry;
    logic      push_ok;
    logic      pop_ok;

    always_comb begin
        new_entry      = '0;
        new_entry.addr = push_addr;
        new_entry.data = push_data;
        new_entry.vld  = 1'b1;
    end

    assign pop_ok  = pop && q0.vld;
    assign push_ok = push && !q1.vld;

    // q0 is always the oldest entry; q1 is only valid when q0 is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b11: q0 <= new_entry;
                2'b01: begin
                    q0 <= q1;
                    q1 <= '0;
                end
                2'b10: begin
                    if (!q0.vld) q0 <= new_entry;
                    else         q1 <= new_entry;
                end
                default: ;
            endcase
        end
    end

    assign head  = q0;
    assign tail  = q1;
    assign count = {q0.vld & q1.vld, q0.vld ^ q1.vld};

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 32x32 register file with queued write-back and read bypass from the queue
module regfile_wb
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic [1:0]        pending
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    wb_entry_t         head;
    wb_entry_t         tail;
    logic              accept;
    logic              push;
    logic              commit;
    logic [NREGS-1:0]  wen;

    assign wb_ready = (pending < 2'd2);
    assign accept   = wb_valid && wb_ready;
    assign push     = accept && (wb_addr != ZERO_REG);
    assign commit   = head.vld && !freeze;

    wb_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (wb_addr),
        .push_data (wb_data),
        .pop       (commit),
        .head      (head),
        .tail      (tail),
        .count     (pending)
    );

    assign wen = wen_decoder5_to_32(head.addr, commit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wen[i]) regs[i] <= head.data;
            end
        end
    end

    // Youngest pending value wins: tail, then head, then the array.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == ZERO_REG)                      rs1_data = '0;
        else if (tail.vld && tail.addr == rs1_addr)    rs1_data = tail.data;
        else if (head.vld && head.addr == rs1_addr)    rs1_data = head.data;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == ZERO_REG)                      rs2_data = '0;
        else if (tail.vld && tail.addr == rs2_addr)    rs2_data = tail.data;
        else if (head.vld && head.addr == rs2_addr)    rs2_data = head.data;
    end

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - scoreboard bench for regfile_wb
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        freeze;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic [1:0]  pending;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] shadow [32];
    int          n_pass  = 0;
    int          n_total = 0;

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .freeze   (freeze),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 32; i++) shadow[i] = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic exp_ready);
        exp_t e;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        #1;
        n_total++;
        if (wb_ready !== exp_ready) $display("FAIL wb_ready_at_write r%0d: got %0b want %0b", a, wb_ready, exp_ready);
        else n_pass++;
        if (exp_ready && a != 5'd0) begin
            sb.push_back('{a, d});
            shadow[a] = d;
        end
        tick();
        wb_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            rs1_addr = e.addr;
            #1;
            n_total++;
            if (rs1_data !== e.data) $display("FAIL bypass_read r%0d: got %h want %h", e.addr, rs1_data, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        freeze = 1'b0; rs1_addr = '0; rs2_addr = '0;
        clear_model();
        tick(); tick();
        rst_n = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            n_total++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
                $display("FAIL reset_read a=%0d: got %h/%h want 0/0", a, rs1_data, rs2_data);
            else n_pass++;
        end
        n_total++;
        if (wb_ready !== 1'b1 || pending !== 2'd0) $display("FAIL reset_status: ready=%0b pending=%0d want 1/0", wb_ready, pending);
        else n_pass++;
    endtask

    task automatic test_write_r5();
        do_write(5'd5, 32'hDEADBEEF, 1'b1);
        n_total++;
        if (pending !== 2'd1) $display("FAIL r5_pending_n1: got %0d want 1", pending);
        else n_pass++;
        tick();
        rs1_addr = 5'd5;
        #1;
        n_total++;
        if (pending !== 2'd0 || rs1_data !== 32'hDEADBEEF)
            $display("FAIL r5_committed: pending=%0d data=%h want 0/deadbeef", pending, rs1_data);
        else n_pass++;
    endtask

    task automatic test_r0_write();
        do_write(5'd0, 32'hFFFFFFFF, 1'b1);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #1;
        n_total++;
        if (pending !== 2'd0 || rs1_data !== 32'h0 || rs2_data !== 32'h0)
            $display("FAIL r0_discard: pending=%0d rs1=%h rs2=%h want 0/0/0", pending, rs1_data, rs2_data);
        else n_pass++;
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        do_write(5'd7, 32'h11, 1'b1);
        do_write(5'd7, 32'h22, 1'b1);
        rs2_addr = 5'd7;
        #1;
        n_total++;
        if (pending !== 2'd2 || rs2_data !== 32'h22) $display("FAIL freeze_full: pending=%0d rs2=%h want 2/22", pending, rs2_data);
        else n_pass++;
        do_write(5'd8, 32'h33, 1'b0);
        rs1_addr = 5'd8;
        #1;
        n_total++;
        if (pending !== 2'd2 || rs1_data !== 32'h0) $display("FAIL freeze_reject: pending=%0d r8=%h want 2/0", pending, rs1_data);
        else n_pass++;
        freeze = 1'b0;
        tick();
        n_total++;
        if (pending !== 2'd1 || rs2_data !== 32'h22) $display("FAIL drain_1: pending=%0d rs2=%h want 1/22", pending, rs2_data);
        else n_pass++;
        tick();
        n_total++;
        if (pending !== 2'd0 || rs2_data !== 32'h22 || rs1_data !== 32'h0)
            $display("FAIL drain_0: pending=%0d r7=%h r8=%h want 0/22/0", pending, rs2_data, rs1_data);
        else n_pass++;
    endtask

    task automatic test_full_commit();
        exp_t e;
        freeze = 1'b1;
        do_write(5'd10, 32'h1, 1'b1);
        do_write(5'd11, 32'h2, 1'b1);
        freeze   = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = 5'd12;
        wb_data  = 32'h3;
        #1;
        n_total++;
        if (wb_ready !== 1'b0) $display("FAIL full_no_passthrough: ready=%0b want 0", wb_ready);
        else n_pass++;
        tick();
        n_total++;
        if (pending !== 2'd1 || wb_ready !== 1'b1) $display("FAIL full_after_commit: pending=%0d ready=%0b want 1/1", pending, wb_ready);
        else n_pass++;
        sb.push_back('{5'd12, 32'h3});
        shadow[12] = 32'h3;
        tick();
        wb_valid = 1'b0;
        e = sb.pop_front();
        rs1_addr = e.addr;
        rs2_addr = 5'd11;
        #1;
        n_total++;
        if (pending !== 2'd1 || rs1_data !== e.data || rs2_data !== 32'h2)
            $display("FAIL enq_and_commit: pending=%0d r12=%h r11=%h want 1/%h/2", pending, rs1_data, rs2_data, e.data);
        else n_pass++;
        tick();
        n_total++;
        if (pending !== 2'd0) $display("FAIL full_drained: pending=%0d want 0", pending);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        freeze = 1'b1;
        do_write(5'd3, 32'hA5, 1'b1);
        do_write(5'd4, 32'h5A, 1'b1);
        rst_n    = 1'b0;
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        clear_model();
        n_total++;
        if (pending !== 2'd0 || wb_ready !== 1'b1 || rs1_data !== 32'h0 || rs2_data !== 32'h0)
            $display("FAIL reset_mid: pending=%0d ready=%0b r3=%h r4=%h want 0/1/0/0", pending, wb_ready, rs1_data, rs2_data);
        else n_pass++;
        freeze = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rs1_addr = 5'd5;
        #1;
        n_total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || pending !== 2'd0)
            $display("FAIL reset_mid_after: r5=%h r4=%h pending=%0d want 0/0/0", rs1_data, rs2_data, pending);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            do_write(5'($urandom_range(0, 31)), $urandom, 1'b1);
        end
        tick(); tick();
        n_total++;
        if (pending !== 2'd0) $display("FAIL b2b_drained: pending=%0d want 0", pending);
        else n_pass++;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(a);
            #1;
            n_total++;
            if (rs1_data !== shadow[a] || rs2_data !== shadow[a])
                $display("FAIL array_r%0d: got %h/%h want %h", a, rs1_data, rs2_data, shadow[a]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_r5();
        test_r0_write();
        test_freeze();
        test_full_commit();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
